// File: rtl/alu_op_sequencer.sv
// Sequencing controller for the four ALU units (subtract, nand, leading ones,
// one-hot index). It accepts one request at a time, executes it from latched
// operands, and holds the registered result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request; the last result stays on o_y/flags
// EXEC  | operands latched; the selected unit's result is registered this edge
// DONE  | result valid and held until the consumer handshakes it
module alu_op_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_y,
   output logic             o_overflow,
   output logic             o_err,
   output logic             o_busy,
   input  logic             i_clr_cnt,
   output logic [CNT_W-1:0] o_ovf_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   localparam int W2   = 2 * WIDTH;
   localparam int LO_W = $clog2(W2 + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             ovf_q, ovf_d, err_q, err_d;
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d, err_cnt_q, err_cnt_d;

   logic [W2-1:0]    cat;
   logic [WIDTH-1:0] sub_y, nand_y, lo_y, oh_y;
   logic             sub_ovf, lo_ovf, lo_run, oh_found, oh_err;
   logic [LO_W-1:0]  lo_cnt;
   logic [WIDTH-1:0] res_y;
   logic             res_ovf, res_err;

   // Unit datapaths, all fed from the latched operands only.
   always_comb begin
      cat     = {b_q, a_q};
      sub_y   = a_q - b_q;
      sub_ovf = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sub_y[WIDTH-1] ^ a_q[WIDTH-1]);
      nand_y  = ~(a_q & b_q);

      lo_cnt = '0;
      lo_run = 1'b1;
      for (int i = W2 - 1; i >= 0; i--) begin
         if (lo_run && cat[i]) lo_cnt = lo_cnt + LO_W'(1);
         else                  lo_run = 1'b0;
      end
      lo_y   = WIDTH'(lo_cnt);
      // Count bits above the result width mean the count no longer fits.
      lo_ovf = |(lo_cnt >> WIDTH);

      // Lowest set bit wins; any further set bit is flagged but not reported.
      oh_y     = '0;
      oh_found = 1'b0;
      oh_err   = 1'b0;
      for (int i = 0; i < W2; i++) begin
         if (cat[i]) begin
            if (oh_found) begin
               oh_err = 1'b1;
            end else begin
               oh_found = 1'b1;
               oh_y     = WIDTH'(i);
            end
         end
      end
   end

   // Select the unit result by latched opcode; illegal opcodes report an error.
   always_comb begin
      res_y   = '0;
      res_ovf = 1'b0;
      res_err = 1'b0;
      case (op_q)
         3'd0: begin
            res_y   = sub_y;
            res_ovf = sub_ovf;
         end
         3'd1: res_y = nand_y;
         3'd2: begin
            res_y   = lo_y;
            res_ovf = lo_ovf;
         end
         3'd3: begin
            res_y   = oh_y;
            res_err = oh_err;
         end
         default: res_err = 1'b1;
      endcase
   end

   // Next-state, operand latch, result register and counter update.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      y_d       = y_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      ovf_cnt_d = ovf_cnt_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               op_d    = i_op;
               a_d     = i_a;
               b_d     = i_b;
               state_d = EXEC;
            end
         end
         EXEC: begin
            y_d   = res_y;
            ovf_d = res_ovf;
            err_d = res_err;
            if (res_ovf && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            if (res_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
            state_d = DONE;
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Clear beats a same-edge increment.
      if (i_clr_cnt) begin
         ovf_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         y_q       <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         ovf_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         y_q       <= y_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         ovf_cnt_q <= ovf_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_ready    = (state_q == IDLE);
   assign o_valid    = (state_q == DONE);
   assign o_busy     = (state_q != IDLE);
   assign o_y        = y_q;
   assign o_overflow = ovf_q;
   assign o_err      = err_q;
   assign o_ovf_cnt  = ovf_cnt_q;
   assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed requests with literal expectations,
// then randomized traffic, all checked against a transaction-level model.
module tb_alu_op_sequencer;

   localparam int W    = 4;
   localparam int M    = 1 << W;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid, i_ready, i_clr_cnt;
   logic [2:0]    i_op;
   logic [W-1:0]  i_a, i_b;
   logic          o_ready, o_valid, o_busy, o_overflow, o_err;
   logic [W-1:0]  o_y;
   logic [CW-1:0] o_ovf_cnt, o_err_cnt;

   alu_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
      .o_y(o_y), .o_overflow(o_overflow), .o_err(o_err), .o_busy(o_busy),
      .i_clr_cnt(i_clr_cnt), .o_ovf_cnt(o_ovf_cnt), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // model: phase 0 = waiting for request, 1 = executing, 2 = result held
   int ph, m_y, m_ovf, m_err, m_oc, m_ec, p_y, p_ovf, p_err;

   logic  cmp_en = 1'b0;
   logic  pin_en = 1'b0;
   logic  tmo    = 1'b0;
   string pin_name = "";
   int    pin_valid, pin_y, pin_ovf, pin_err, pin_oc, pin_ec;

   task automatic calc(input int op, input int a, input int b,
                       output int y, output int ovf, output int err);
      int v, sa, sb, d, cnt;
      v   = b * M + a;
      y   = 0;
      ovf = 0;
      err = 0;
      case (op)
         0: begin
            sa  = (a >= M / 2) ? a - M : a;
            sb  = (b >= M / 2) ? b - M : b;
            d   = sa - sb;
            y   = (a - b) & (M - 1);
            ovf = (d > M / 2 - 1 || d < -M / 2) ? 1 : 0;
         end
         1: y = ~(a & b) & (M - 1);
         2: begin
            cnt = 0;
            for (int i = 2 * W - 1; i >= 0; i--) begin
               if (((v >> i) & 1) == 0) break;
               cnt++;
            end
            y   = cnt % M;
            ovf = (cnt > M - 1) ? 1 : 0;
         end
         3: begin
            if (v != 0) begin
               y   = $clog2(v & -v);
               err = ($countones(v) > 1) ? 1 : 0;
            end
         end
         default: err = 1;
      endcase
   endtask

   // Transaction-level model of the sequencer.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph = 0; m_y = 0; m_ovf = 0; m_err = 0; m_oc = 0; m_ec = 0;
      end else begin
         case (ph)
            0: if (i_valid) begin
                  calc(int'(i_op), int'(i_a), int'(i_b), p_y, p_ovf, p_err);
                  ph = 1;
               end
            1: begin
                  m_y = p_y; m_ovf = p_ovf; m_err = p_err;
                  if (p_ovf != 0 && m_oc < CMAX) m_oc++;
                  if (p_err != 0 && m_ec < CMAX) m_ec++;
                  ph = 2;
               end
            default: if (i_ready) ph = 0;
         endcase
         if (i_clr_cnt) begin
            m_oc = 0;
            m_ec = 0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: reset values, model, and pinned literals.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_ready", int'(o_ready), 1);
         check("rst_valid", int'(o_valid), 0);
         check("rst_busy",  int'(o_busy), 0);
         check("rst_y",     int'(o_y), 0);
         check("rst_ovf",   int'(o_overflow), 0);
         check("rst_err",   int'(o_err), 0);
         check("rst_ovf_cnt", int'(o_ovf_cnt), 0);
         check("rst_err_cnt", int'(o_err_cnt), 0);
      end else if (cmp_en) begin
         check("ready_timeout", int'(tmo), 0);
         check("ready",   int'(o_ready), (ph == 0) ? 1 : 0);
         check("valid",   int'(o_valid), (ph == 2) ? 1 : 0);
         check("busy",    int'(o_busy),  (ph != 0) ? 1 : 0);
         check("ovf_cnt", int'(o_ovf_cnt), m_oc);
         check("err_cnt", int'(o_err_cnt), m_ec);
         if (ph == 2) begin
            check("y",   int'(o_y), m_y);
            check("ovf", int'(o_overflow), m_ovf);
            check("err", int'(o_err), m_err);
         end
         if (pin_en) begin
            if (pin_valid >= 0) check({pin_name, "_valid"}, int'(o_valid), pin_valid);
            if (pin_y >= 0)     check({pin_name, "_y"}, int'(o_y), pin_y);
            if (pin_ovf >= 0)   check({pin_name, "_ovf"}, int'(o_overflow), pin_ovf);
            if (pin_err >= 0)   check({pin_name, "_err"}, int'(o_err), pin_err);
            if (pin_oc >= 0)    check({pin_name, "_ovf_cnt"}, int'(o_ovf_cnt), pin_oc);
            if (pin_ec >= 0)    check({pin_name, "_err_cnt"}, int'(o_err_cnt), pin_ec);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_pins(input string nm, input int v, input int y, input int ovf,
                           input int err, input int oc, input int ec);
      pin_name  = nm;
      pin_valid = v;
      pin_y     = y;
      pin_ovf   = ovf;
      pin_err   = err;
      pin_oc    = oc;
      pin_ec    = ec;
      pin_en    = 1'b1;
   endtask

   task automatic run_op(input string nm, input int op, input int a, input int b,
                         input int hold, input bit clr_exec, input bit rst_mid,
                         input int ey, input int eovf, input int eerr,
                         input int eoc, input int eec);
      int n;
      n = 0;
      while (!o_ready && n < 20) begin
         step();
         n++;
      end
      if (!o_ready) tmo = 1'b1;
      i_valid   = 1'b1;
      i_op      = 3'(op);
      i_a       = W'(a);
      i_b       = W'(b);
      i_ready   = 1'b0;
      i_clr_cnt = 1'b0;
      set_pins({nm, "_lat1"}, 0, -1, -1, -1, -1, -1);
      step();
      i_valid = 1'b0;
      i_a     = W'($urandom);
      i_b     = W'($urandom);
      i_op    = 3'($urandom);
      if (rst_mid) begin
         pin_en = 1'b0;
         rst    = 1'b1;
         step();
         rst    = 1'b0;
         return;
      end
      if (clr_exec) i_clr_cnt = 1'b1;
      set_pins(nm, 1, ey, eovf, eerr, eoc, eec);
      step();
      pin_en    = 1'b0;
      i_clr_cnt = 1'b0;
      for (int h = 0; h < hold; h++) begin
         i_a     = W'($urandom);
         i_valid = 1'($urandom);
         step();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_clr_cnt = 1'b0;
      i_op = '0; i_a = '0; i_b = '0;
      pin_valid = -1; pin_y = -1; pin_ovf = -1; pin_err = -1; pin_oc = -1; pin_ec = -1;
      step();
      step();
      rst    = 1'b0;
      cmp_en = 1'b1;
      step();

      run_op("sub_ovf",   0, 4'b0101, 4'b1101, 0, 0, 0, 4'b1000, 1, 0, 1, 0);
      run_op("nand",      1, 4'b1100, 4'b1010, 0, 0, 0, 4'b0111, 0, 0, 1, 0);
      run_op("lead_ones", 2, 4'b1100, 4'b1111, 0, 0, 0, 4'b0110, 0, 0, 1, 0);
      run_op("oh_single", 3, 4'b0000, 4'b0010, 0, 0, 0, 4'b0101, 0, 0, 1, 0);
      run_op("oh_multi",  3, 4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 0, 1, 1, 1);
      run_op("illegal_bp", 5, 4'b1111, 4'b1111, 5, 0, 0, 0, 0, 1, 1, 2);

      i_clr_cnt = 1'b1;
      step();
      i_clr_cnt = 1'b0;
      run_op("sat1", 5, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
      run_op("sat2", 6, 3, 4, 1, 0, 0, 0, 0, 1, 0, 2);
      run_op("sat3", 7, 5, 6, 0, 0, 0, 0, 0, 1, 0, 3);
      run_op("sat4", 5, 7, 8, 2, 0, 0, 0, 0, 1, 0, 3);
      run_op("clr_exec", 5, 9, 9, 0, 1, 0, 0, 0, 1, 0, 0);
      run_op("sub_ovf2", 0, 4'b0111, 4'b1000, 0, 0, 0, 4'b1111, 1, 0, 1, 0);
      run_op("rst_mid", 0, 4'b0101, 4'b1101, 0, 0, 1, -1, -1, -1, -1, -1);
      run_op("after_rst", 1, 4'b1100, 4'b1010, 0, 0, 0, 4'b0111, 0, 0, 0, 0);

      for (int c = 0; c < 3000; c++) begin
         i_valid   = ($urandom % 4) != 0;
         i_op      = 3'($urandom);
         i_a       = W'($urandom);
         if ($urandom % 2 == 0) i_b = W'(1 << ($urandom % W));
         else                   i_b = W'($urandom);
         if ($urandom % 3 == 0) i_a = '0;
         i_ready   = 1'($urandom);
         i_clr_cnt = ($urandom % 24) == 0;
         rst       = ($urandom % 400) == 0;
         step();
      end
      rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr_cnt = 1'b0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
